// File: rtl/ps2_pkg.sv
// Shared PS/2 scancode constants, event record and decoder state encoding
// for the key event controller.
package ps2_pkg;

   localparam logic [7:0] PS2_E0         = 8'hE0;
   localparam logic [7:0] PS2_F0         = 8'hF0;
   localparam logic [7:0] PS2_E1         = 8'hE1;
   localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;

   // Device responses that never represent a key
   localparam logic [7:0] PS2_RSP_ERR0   = 8'h00;
   localparam logic [7:0] PS2_RSP_BAT_OK = 8'hAA;
   localparam logic [7:0] PS2_RSP_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RSP_BAT_NG = 8'hFC;
   localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;
   localparam logic [7:0] PS2_RSP_ERRFF  = 8'hFF;

   // Bytes that follow E1 in the Pause make sequence
   localparam logic [2:0] PS2_PAUSE_TAIL = 3'd7;

   typedef struct packed {
      logic       brk;
      logic       ext;
      logic [7:0] code;
   } ps2_evt_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PFX_E0   = 3'd1,
      PFX_F0   = 3'd2,
      PFX_E0F0 = 3'd3,
      SKIP     = 3'd4
   } ps2_dec_state_t;

   function automatic logic is_response(input logic [7:0] b);
      logic r;
      case (b)
         PS2_RSP_ERR0, PS2_RSP_BAT_OK, PS2_RSP_ECHO, PS2_RSP_ACK,
         PS2_RSP_BAT_NG, PS2_RSP_RESEND, PS2_RSP_ERRFF: r = 1'b1;
         default:                                       r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous first-word-fall-through event FIFO; head is read straight from
// registered storage, and a push into a full FIFO is only taken alongside a pop.
module ps2_evt_fifo
   import ps2_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = ps2_evt_t
)(
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  T     push_data,
   input  logic ready,
   output T     head,
   output logic valid,
   output logic drop
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   T               mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic [CW-1:0]  count_next;
   logic           full;
   logic           do_pop;
   logic           do_push;

   assign full    = (count == CW'(DEPTH));
   assign do_pop  = valid & ready;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   // occupancy after this cycle's push/pop
   always_comb begin
      count_next = count;
      case ({do_push, do_pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // storage, pointers, occupancy and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         valid  <= 1'b0;
         drop   <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_next;
         valid <= (count_next != CW'(0));
         drop  <= push & ~do_push;
      end
   end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// Turns the raw PS/2 byte stream into make/break key events, filtering
// prefixes, device responses and typematic repeats, and queues them for a consumer.
module ps2_key_event_ctrl
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH    = 4,
   parameter int TIMEOUT_CYC   = 2_000_000,
   parameter int FILTER_REPEAT = 1
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] byte_i,
   input  logic       byte_valid_i,
   output logic       evt_valid_o,
   input  logic       evt_ready_i,
   output logic [7:0] evt_code_o,
   output logic       evt_ext_o,
   output logic       evt_break_o,
   output logic       drop_o
);

   localparam int             TW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic           FILT    = (FILTER_REPEAT != 0);

   ps2_dec_state_t state;
   ps2_dec_state_t state_next;
   logic [2:0]     skip_cnt;
   logic [2:0]     skip_next;
   logic [TW-1:0]  to_cnt;
   logic [TW-1:0]  to_next;
   logic [511:0]   held;
   logic           emit;
   ps2_evt_t       evt;
   logic           push;
   ps2_evt_t       head;

   // decoder next state and event emission
   always_comb begin
      state_next = state;
      skip_next  = skip_cnt;
      to_next    = to_cnt;
      emit       = 1'b0;
      evt        = '0;
      if (byte_valid_i) begin
         to_next = '0;
         case (state)
            IDLE: begin
               if (byte_i == PS2_E0) begin
                  state_next = PFX_E0;
               end else if (byte_i == PS2_F0) begin
                  state_next = PFX_F0;
               end else if (byte_i == PS2_E1) begin
                  state_next = SKIP;
                  skip_next  = PS2_PAUSE_TAIL;
               end else if (is_response(byte_i)) begin
                  state_next = IDLE;
               end else begin
                  emit = 1'b1;
                  evt  = '{brk: 1'b0, ext: 1'b0, code: byte_i};
               end
            end
            PFX_E0: begin
               if (byte_i == PS2_F0) begin
                  state_next = PFX_E0F0;
               end else if (byte_i == PS2_FAKE_SHIFT) begin
                  state_next = IDLE;
               end else begin
                  state_next = IDLE;
                  emit       = 1'b1;
                  evt        = '{brk: 1'b0, ext: 1'b1, code: byte_i};
               end
            end
            PFX_F0: begin
               if (byte_i == PS2_E0) begin
                  state_next = PFX_E0;
               end else begin
                  state_next = IDLE;
                  emit       = 1'b1;
                  evt        = '{brk: 1'b1, ext: 1'b0, code: byte_i};
               end
            end
            PFX_E0F0: begin
               if (byte_i == PS2_FAKE_SHIFT) begin
                  state_next = IDLE;
               end else if (byte_i == PS2_E0) begin
                  state_next = PFX_E0;
               end else begin
                  state_next = IDLE;
                  emit       = 1'b1;
                  evt        = '{brk: 1'b1, ext: 1'b1, code: byte_i};
               end
            end
            SKIP: begin
               // the byte that brings the count to zero is the last one swallowed
               if (skip_cnt <= 3'd1) begin
                  state_next = IDLE;
                  skip_next  = 3'd0;
               end else begin
                  skip_next  = skip_cnt - 3'd1;
               end
            end
            default: begin
               state_next = IDLE;
               skip_next  = 3'd0;
            end
         endcase
      end else if (state != IDLE) begin
         if (to_cnt == TO_LAST) begin
            state_next = IDLE;
            skip_next  = 3'd0;
            to_next    = '0;
         end else begin
            to_next = to_cnt + TW'(1);
         end
      end else begin
         to_next = '0;
      end
   end

   assign push = emit & ~(FILT & ~evt.brk & held[{evt.ext, evt.code}]);

   // decoder state, pause skip counter, prefix timeout counter and held-key map
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         skip_cnt <= 3'd0;
         to_cnt   <= '0;
         held     <= '0;
      end else begin
         state    <= state_next;
         skip_cnt <= skip_next;
         to_cnt   <= to_next;
         if (emit) begin
            held[{evt.ext, evt.code}] <= ~evt.brk;
         end
      end
   end

   ps2_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (ps2_evt_t)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (evt),
      .ready     (evt_ready_i),
      .head      (head),
      .valid     (evt_valid_o),
      .drop      (drop_o)
   );

   assign evt_code_o  = head.code;
   assign evt_ext_o   = head.ext;
   assign evt_break_o = head.brk;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Self-checking bench: a prefix/queue model of the key event rules checked
// against the DUT every cycle, plus directed sequences with literal expectations.
module tb_ps2_key_event_ctrl;

   localparam int DEPTH = 4;
   localparam int TO    = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] byte_i;
   logic       byte_valid_i;
   logic       evt_valid_o;
   logic       evt_ready_i;
   logic [7:0] evt_code_o;
   logic       evt_ext_o;
   logic       evt_break_o;
   logic       drop_o;

   ps2_key_event_ctrl #(
      .FIFO_DEPTH    (DEPTH),
      .TIMEOUT_CYC   (TO),
      .FILTER_REPEAT (1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .byte_i       (byte_i),
      .byte_valid_i (byte_valid_i),
      .evt_valid_o  (evt_valid_o),
      .evt_ready_i  (evt_ready_i),
      .evt_code_o   (evt_code_o),
      .evt_ext_o    (evt_ext_o),
      .evt_break_o  (evt_break_o),
      .drop_o       (drop_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // model state: events are {brk, ext, code}
   logic [9:0] mq[$];
   bit         held_m[512];
   bit         m_ext, m_brk;
   int         m_skip, m_idle;
   bit         drop_exp;

   logic [9:0] dut_log[$];
   int         drop_seen = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [9:0] log_at(input int i);
      if (i < dut_log.size()) return dut_log[i];
      return 10'h3FF;
   endfunction

   task automatic model_clear();
      mq.delete();
      for (int i = 0; i < 512; i++) held_m[i] = 1'b0;
      m_ext = 1'b0; m_brk = 1'b0; m_skip = 0; m_idle = 0; drop_exp = 1'b0;
   endtask

   // one byte through the prefix rules; have=1 when a key event results
   task automatic model_byte(input logic [7:0] b, output bit have, output logic [9:0] e);
      bit in_pfx;
      have = 1'b0;
      e = 10'h000;
      in_pfx = m_ext || m_brk;
      if (m_skip > 0) begin
         m_skip--;
      end else if (b == 8'hE1 && !in_pfx) begin
         m_skip = 7;
      end else if (b == 8'hE0 && !(m_ext && !m_brk)) begin
         m_ext = 1'b1; m_brk = 1'b0;
      end else if (b == 8'hF0 && !m_brk) begin
         m_brk = 1'b1;
      end else if (m_ext && b == 8'h12) begin
         m_ext = 1'b0; m_brk = 1'b0;
      end else if (!in_pfx && (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF})) begin
         have = 1'b0;
      end else begin
         have = 1'b1;
         e = {m_brk, m_ext, b};
         m_ext = 1'b0; m_brk = 1'b0;
      end
   endtask

   initial begin : model_proc
      bit pop_now, have;
      logic [9:0] e;
      model_clear();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            model_clear();
         end else begin
            pop_now = (mq.size() > 0) && evt_ready_i;
            have = 1'b0;
            e = 10'h000;
            if (byte_valid_i) begin
               m_idle = 0;
               model_byte(byte_i, have, e);
            end else begin
               m_idle++;
               if ((m_ext || m_brk || m_skip > 0) && m_idle >= TO) begin
                  m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
               end
            end
            if (pop_now) void'(mq.pop_front());
            drop_exp = 1'b0;
            if (have) begin
               if (!(e[9] == 1'b0 && held_m[e[8:0]])) begin
                  if (mq.size() < DEPTH) mq.push_back(e);
                  else drop_exp = 1'b1;
               end
               held_m[e[8:0]] = !e[9];
            end
         end
      end
   end

   initial begin : compare_proc
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            chk("evt_valid", {31'd0, evt_valid_o}, {31'd0, mq.size() != 0});
            if (mq.size() != 0)
               chk("evt_head", {22'd0, evt_break_o, evt_ext_o, evt_code_o}, {22'd0, mq[0]});
            chk("drop", {31'd0, drop_o}, {31'd0, drop_exp});
            if (evt_valid_o && evt_ready_i)
               dut_log.push_back({evt_break_o, evt_ext_o, evt_code_o});
            if (drop_o) drop_seen++;
         end
      end
   end

   task automatic send(input logic [7:0] b);
      byte_i = b;
      byte_valid_i = 1'b1;
      @(posedge clk); #1;
      byte_valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_seq(input logic [7:0] s[], input int gap);
      foreach (s[i]) begin send(s[i]); idle(gap); end
   endtask

   initial begin : stim
      int base, dbase;
      logic [7:0] keys[8] = '{8'h1C, 8'h1D, 8'h15, 8'h24, 8'h75, 8'h7C, 8'h2C, 8'h6B};
      logic [7:0] rsp[7]  = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
      rst_n = 1'b0; byte_i = 8'h00; byte_valid_i = 1'b0; evt_ready_i = 1'b0;
      idle(3);
      chk("reset_valid", {31'd0, evt_valid_o}, 32'd0);
      chk("reset_drop", {31'd0, drop_o}, 32'd0);
      chk("reset_head", {22'd0, evt_break_o, evt_ext_o, evt_code_o}, 32'd0);
      rst_n = 1'b1;
      idle(2);

      // plain make and break
      evt_ready_i = 1'b1;
      base = dut_log.size();
      send_seq('{8'h1C, 8'hF0, 8'h1C}, 1);
      idle(4);
      chk("t1_count", dut_log.size() - base, 32'd2);
      chk("t1_make", {22'd0, log_at(base)}, 32'h01C);
      chk("t1_break", {22'd0, log_at(base + 1)}, 32'h21C);

      // extended keys and PrtSc fake shift
      base = dut_log.size();
      send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h12, 8'hE0, 8'h7C}, 1);
      idle(4);
      chk("t2_count", dut_log.size() - base, 32'd3);
      chk("t2_ext_make", {22'd0, log_at(base)}, 32'h175);
      chk("t2_ext_break", {22'd0, log_at(base + 1)}, 32'h375);
      chk("t2_prtsc", {22'd0, log_at(base + 2)}, 32'h17C);

      // typematic repeats suppressed
      base = dut_log.size();
      send_seq('{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C}, 1);
      idle(4);
      chk("t3_count", dut_log.size() - base, 32'd2);
      chk("t3_make", {22'd0, log_at(base)}, 32'h01C);
      chk("t3_break", {22'd0, log_at(base + 1)}, 32'h21C);

      // overflow with consumer stalled
      evt_ready_i = 1'b0;
      base = dut_log.size();
      dbase = drop_seen;
      send_seq('{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C}, 1);
      idle(3);
      chk("t4_drops", drop_seen - dbase, 32'd1);
      evt_ready_i = 1'b1;
      idle(6);
      chk("t4_count", dut_log.size() - base, 32'd4);
      chk("t4_ev0", {22'd0, log_at(base)}, 32'h015);
      chk("t4_ev1", {22'd0, log_at(base + 1)}, 32'h01D);
      chk("t4_ev2", {22'd0, log_at(base + 2)}, 32'h024);
      chk("t4_ev3", {22'd0, log_at(base + 3)}, 32'h02D);
      base = dut_log.size();
      send_seq('{8'hF0, 8'h2C}, 1);
      idle(4);
      chk("t4_late_break", {22'd0, log_at(base)}, 32'h22C);

      // abandoned E0 prefix, then the Pause sequence
      base = dut_log.size();
      send(8'hE0);
      idle(TO);
      send(8'h1C);
      idle(4);
      chk("t5_timeout", {22'd0, log_at(base)}, 32'h01C);
      base = dut_log.size();
      send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77}, 1);
      idle(4);
      chk("t5_pause_silent", dut_log.size() - base, 32'd0);

      // reset with a partial prefix and two queued events
      evt_ready_i = 1'b0;
      send_seq('{8'h34, 8'h33, 8'hF0}, 1);
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
      chk("t6_flushed", {31'd0, evt_valid_o}, 32'd0);
      evt_ready_i = 1'b1;
      base = dut_log.size();
      send(8'h1C);
      idle(4);
      chk("t6_after_reset", {22'd0, log_at(base)}, 32'h01C);
      chk("t6_count", dut_log.size() - base, 32'd1);

      // randomized traffic checked every cycle against the model
      for (int n = 0; n < 600; n++) begin
         int r;
         int gap;
         logic [7:0] b;
         r = $urandom_range(0, 99);
         if (r < 15)      b = 8'hE0;
         else if (r < 32) b = 8'hF0;
         else if (r < 35) b = 8'hE1;
         else if (r < 40) b = 8'h12;
         else if (r < 46) b = rsp[$urandom_range(0, 6)];
         else             b = keys[$urandom_range(0, 7)];
         evt_ready_i = ($urandom_range(0, 3) != 0);
         send(b);
         r = $urandom_range(0, 99);
         if (r < 40)      gap = 0;
         else if (r < 90) gap = $urandom_range(1, 4);
         else             gap = $urandom_range(TO - 2, TO + 2);
         idle(gap);
      end
      evt_ready_i = 1'b1;
      idle(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
